// File: rtl/bids_cmd_sequencer_if.sv
// Host-side command/response bundle for the BIDS22 command sequencer.
// The host is the master; the sequencer is the slave.
interface bids_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [3:0]  rsp_op;
  logic [2:0]  rsp_err;
  logic [2:0]  rsp_win;
  logic [31:0] rsp_maxbid;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_op,
    input  rsp_err,
    input  rsp_win,
    input  rsp_maxbid
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_op,
    output rsp_err,
    output rsp_win,
    output rsp_maxbid
  );
endinterface

// File: rtl/bids_cmd_sequencer.sv
// BIDS22 command sequencer: buffers host commands and replays them
// onto the bid controller, sequencing full auction rounds.
module bids_cmd_sequencer #(
  parameter int DEPTH         = 4,
  parameter int CLOSE_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bids_cmd_sequencer_if.slave  host,
  output logic [3:0]           C_op,
  output logic [31:0]          C_data,
  output logic                 C_start,
  input  logic                 ready,
  input  logic [2:0]           err,
  input  logic                 roundOver,
  input  logic                 X_win,
  input  logic                 Y_win,
  input  logic                 Z_win,
  input  logic [31:0]          maxBid,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLOSE_TIMEOUT) + 1;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOCK  = 4'd2;
  localparam logic [3:0] OP_LAST  = 4'd8;
  localparam logic [3:0] OP_ROUND = 4'd9;

  localparam logic [2:0] E_TMO = 3'b111;
  localparam logic [2:0] E_ILL = 3'b110;

  localparam logic [TW-1:0] T_MAX = TW'(CLOSE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ROUND,
    CLOSE,
    RESP
  } state_t;

  logic [3:0]    op_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [3:0]    head_op;
  logic [31:0]   head_data;

  state_t        state;
  logic [3:0]    cur_op;
  logic [31:0]   rcnt;
  logic [TW-1:0] wcnt;
  logic [2:0]    sticky;

  logic          rsp_valid;
  logic [3:0]    rsp_op;
  logic [2:0]    rsp_err;
  logic [2:0]    rsp_win;
  logic [31:0]   rsp_maxbid;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = host.cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty && ready;
  assign head_op   = op_mem[rptr];
  assign head_data = data_mem[rptr];

  assign host.cmd_ready  = !full;
  assign host.rsp_valid  = rsp_valid;
  assign host.rsp_op     = rsp_op;
  assign host.rsp_err    = rsp_err;
  assign host.rsp_win    = rsp_win;
  assign host.rsp_maxbid = rsp_maxbid;

  assign busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wptr]   <= host.cmd_op;
      data_mem[wptr] <= host.cmd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_op     <= OP_NOP;
      rcnt       <= '0;
      wcnt       <= '0;
      sticky     <= '0;
      C_op       <= OP_NOP;
      C_data     <= '0;
      C_start    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_op     <= '0;
      rsp_err    <= '0;
      rsp_win    <= '0;
      rsp_maxbid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_op <= head_op;
            unique case (1'b1)
              (head_op <= OP_LAST): begin
                state  <= ISSUE;
                C_op   <= head_op;
                C_data <= head_data;
              end
              (head_op == OP_ROUND): begin
                state   <= ROUND;
                C_start <= 1'b1;
                C_op    <= OP_LOCK;
                C_data  <= '0;
                rcnt    <= (head_data == '0) ? 32'd1 : head_data;
                sticky  <= '0;
              end
              default: begin
                state      <= RESP;
                rsp_valid  <= 1'b1;
                rsp_op     <= head_op;
                rsp_err    <= E_ILL;
                rsp_win    <= '0;
                rsp_maxbid <= '0;
              end
            endcase
          end
        end

        ISSUE: begin
          state      <= RESP;
          rsp_valid  <= 1'b1;
          rsp_op     <= cur_op;
          rsp_err    <= err;
          rsp_win    <= '0;
          rsp_maxbid <= '0;
          C_op       <= OP_NOP;
          C_data     <= '0;
        end

        ROUND: begin
          // first non-zero error of the hold window wins
          if (sticky == '0) sticky <= err;
          if (rcnt == 32'd1) begin
            state   <= CLOSE;
            C_start <= 1'b0;
            wcnt    <= '0;
          end else begin
            rcnt <= rcnt - 32'd1;
          end
        end

        CLOSE: begin
          if (roundOver) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_op     <= cur_op;
            rsp_err    <= (sticky != '0) ? sticky : err;
            rsp_win    <= {X_win, Y_win, Z_win};
            rsp_maxbid <= maxBid;
            C_op       <= OP_NOP;
          end else if (wcnt == T_MAX) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_op     <= cur_op;
            rsp_err    <= E_TMO;
            rsp_win    <= '0;
            rsp_maxbid <= '0;
            C_op       <= OP_NOP;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end

        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bids_cmd_sequencer.sv
// Bench for bids_cmd_sequencer: a command-level schedule model plus
// a small controller stub, checked every cycle on the falling edge.
module tb_bids_cmd_sequencer;

  localparam int          DEPTH = 4;
  localparam int          CTO   = 4;
  localparam logic [31:0] KEY   = 32'h0000_1234;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d;
  } cmd_t;

  typedef struct {
    logic [3:0]  cop;
    logic [31:0] cdata;
    logic        cs;
    logic        rv;
    logic [3:0]  rop;
    logic [2:0]  rerr;
    logic [2:0]  rwin;
    logic [31:0] rmb;
  } cyc_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  err;
    logic [2:0]  win;
    logic [31:0] mb;
  } rsp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready   = 1'b1;
  logic [2:0]  err;
  logic        roundOver;
  logic        X_win;
  logic        Y_win;
  logic        Z_win;
  logic [31:0] maxBid;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        busy;

  logic [2:0]  err_force = 3'b000;
  logic        ro_en     = 1'b0;
  logic [2:0]  win_v     = 3'b000;
  logic [31:0] mb_v      = 32'd0;
  logic        cs_d      = 1'b0;

  int tests = 0;
  int fails = 0;
  int cs_cnt = 0;

  cmd_t mq[$];
  cyc_t sched[$];
  cyc_t cur;
  bit   cur_v = 1'b0;
  logic [3:0]  h_op  = '0;
  logic [2:0]  h_err = '0;
  logic [2:0]  h_win = '0;
  logic [31:0] h_mb  = '0;
  rsp_t rsp_log[$];

  bids_cmd_sequencer_if h ();

  bids_cmd_sequencer #(
    .DEPTH         (DEPTH),
    .CLOSE_TIMEOUT (CTO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .host      (h),
    .C_op      (C_op),
    .C_data    (C_data),
    .C_start   (C_start),
    .ready     (ready),
    .err       (err),
    .roundOver (roundOver),
    .X_win     (X_win),
    .Y_win     (Y_win),
    .Z_win     (Z_win),
    .maxBid    (maxBid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // controller stub: Unlock (1) with a wrong key reports 001
  assign err = (err_force != 3'b000) ? err_force :
               ((C_op == 4'd1) && (C_data != KEY)) ? 3'b001 : 3'b000;
  assign roundOver = reset_n && ro_en && cs_d && !C_start;
  assign {X_win, Y_win, Z_win} = win_v;
  assign maxBid = mb_v;

  always @(posedge clk) cs_d <= C_start;

  function automatic cyc_t mk(
    input logic [3:0] cop, input logic [31:0] cd, input logic cs,
    input logic rv, input logic [3:0] rop, input logic [2:0] re,
    input logic [2:0] rw, input logic [31:0] rm);
    cyc_t e;
    e.cop = cop; e.cdata = cd; e.cs = cs; e.rv = rv;
    e.rop = rop; e.rerr = re; e.rwin = rw; e.rmb = rm;
    return e;
  endfunction

  function automatic logic [2:0] err_of(input logic [3:0] op,
                                        input logic [31:0] d);
    if (err_force != 3'b000) return err_force;
    if ((op == 4'd1) && (d != KEY)) return 3'b001;
    return 3'b000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected per-cycle schedule of one command, from its pop onward
  task automatic plan(input cmd_t c);
    int n;
    int k;
    logic [2:0] st;
    logic [2:0] ce;
    if (c.op <= 4'd8) begin
      sched.push_back(mk(c.op, c.d, 1'b0, 1'b0, 0, 0, 0, 0));
      sched.push_back(mk(4'd0, 0, 1'b0, 1'b1, c.op,
                         err_of(c.op, c.d), 0, 0));
    end else if (c.op == 4'd9) begin
      n = (c.d == 0) ? 1 : int'(c.d);
      k = ro_en ? 1 : CTO;
      for (int i = 0; i < n; i++)
        sched.push_back(mk(4'd2, 0, 1'b1, 1'b0, 0, 0, 0, 0));
      for (int i = 0; i < k; i++)
        sched.push_back(mk(4'd2, 0, 1'b0, 1'b0, 0, 0, 0, 0));
      st = err_of(4'd2, 0);
      ce = err_of(4'd2, 0);
      if (ro_en)
        sched.push_back(mk(4'd0, 0, 1'b0, 1'b1, 4'd9,
                           (st != 0) ? st : ce, win_v, mb_v));
      else
        sched.push_back(mk(4'd0, 0, 1'b0, 1'b1, 4'd9, 3'b111, 0, 0));
    end else begin
      sched.push_back(mk(4'd0, 0, 1'b0, 1'b1, c.op, 3'b110, 0, 0));
    end
  endtask

  initial begin
    cmd_t c;
    bit acc;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        sched.delete();
        cur_v = 1'b0;
        h_op = '0; h_err = '0; h_win = '0; h_mb = '0;
      end else begin
        acc = h.cmd_valid && (mq.size() < DEPTH);
        if (cur_v) begin
          if (sched.size() > 0) cur = sched.pop_front();
          else cur_v = 1'b0;
        end else if ((mq.size() > 0) && ready) begin
          c = mq.pop_front();
          plan(c);
          cur = sched.pop_front();
          cur_v = 1'b1;
        end
        if (acc) begin
          c.op = h.cmd_op;
          c.d  = h.cmd_data;
          mq.push_back(c);
        end
        if (cur_v && cur.rv) begin
          h_op = cur.rop; h_err = cur.rerr;
          h_win = cur.rwin; h_mb = cur.rmb;
        end
      end
    end
  end

  initial begin
    cyc_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      e = cur_v ? cur : mk(0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
      chk("C_op",       32'(C_op),          32'(e.cop));
      chk("C_data",     C_data,             e.cdata);
      chk("C_start",    32'(C_start),       32'(e.cs));
      chk("rsp_valid",  32'(h.rsp_valid),   32'(e.rv));
      chk("rsp_op",     32'(h.rsp_op),      32'(h_op));
      chk("rsp_err",    32'(h.rsp_err),     32'(h_err));
      chk("rsp_win",    32'(h.rsp_win),     32'(h_win));
      chk("rsp_maxbid", h.rsp_maxbid,       h_mb);
      chk("cmd_ready",  32'(h.cmd_ready),   32'(mq.size() < DEPTH));
      chk("busy",       32'(busy),          32'(cur_v || (mq.size() != 0)));
      if (h.rsp_valid) begin
        r.op = h.rsp_op; r.err = h.rsp_err;
        r.win = h.rsp_win; r.mb = h.rsp_maxbid;
        rsp_log.push_back(r);
      end
      if (C_start) cs_cnt++;
    end
  end

  task automatic push(input logic [3:0] op, input logic [31:0] d);
    h.cmd_valid = 1'b1;
    h.cmd_op    = op;
    h.cmd_data  = d;
    @(posedge clk); #1;
    h.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((cur_v || (mq.size() != 0)) && (n < 300)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 32'(cur_v || (mq.size() != 0)), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic exp_rsp(input int idx, input logic [3:0] op,
                         input logic [2:0] er, input logic [2:0] w,
                         input logic [31:0] mb);
    if (idx >= rsp_log.size()) begin
      chk("rsp_count", 32'(rsp_log.size()), 32'(idx + 1));
    end else begin
      chk("log_op",  32'(rsp_log[idx].op),  32'(op));
      chk("log_err", 32'(rsp_log[idx].err), 32'(er));
      chk("log_win", 32'(rsp_log[idx].win), 32'(w));
      chk("log_mb",  rsp_log[idx].mb,       mb);
    end
  endtask

  task automatic clear_logs();
    rsp_log.delete();
    cs_cnt = 0;
  endtask

  initial begin
    h.cmd_valid = 1'b0;
    h.cmd_op    = '0;
    h.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_cmd_ready", 32'(h.cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_C_op",      32'(C_op),        32'd0);

    // abort a round on its second hold cycle
    ro_en = 1'b1;
    push(4'd9, 32'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_round_cs", 32'(C_start), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_cs",      32'(C_start),     32'd0);
    chk("abort_ready",   32'(h.cmd_ready), 32'd1);
    chk("abort_busy",    32'(busy),        32'd0);
    chk("abort_rsp",     32'(h.rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 chk("abort_no_rsp", 32'(rsp_log.size()), 32'd0);

    clear_logs();
    push(4'd3, 32'd100);
    push(4'd2, 32'h0000_00A5);
    drain();
    chk("plain_rsps", 32'(rsp_log.size()), 32'd2);
    exp_rsp(0, 4'd3, 3'b000, 3'b000, 32'd0);
    exp_rsp(1, 4'd2, 3'b000, 3'b000, 32'd0);

    clear_logs();
    ro_en = 1'b1; win_v = 3'b100; mb_v = 32'd40;
    push(4'd9, 32'd3);
    drain();
    chk("round3_cs_cycles", 32'(cs_cnt), 32'd3);
    exp_rsp(0, 4'd9, 3'b000, 3'b100, 32'd40);

    clear_logs();
    ro_en = 1'b0;
    push(4'd9, 32'd0);
    drain();
    chk("round0_cs_cycles", 32'(cs_cnt), 32'd1);
    exp_rsp(0, 4'd9, 3'b111, 3'b000, 32'd0);

    clear_logs();
    ro_en = 1'b1; err_force = 3'b101; win_v = 3'b010; mb_v = 32'd77;
    push(4'd9, 32'd2);
    drain();
    err_force = 3'b000;
    exp_rsp(0, 4'd9, 3'b101, 3'b010, 32'd77);

    clear_logs();
    ready = 1'b0;
    push(4'd5, 32'd10);
    push(4'd6, 32'd11);
    push(4'd7, 32'd12);
    push(4'd8, 32'd13);
    chk("full_ready", 32'(h.cmd_ready), 32'd0);
    push(4'd0, 32'd99);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_C_op", 32'(C_op), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    drain();
    chk("fill_rsps", 32'(rsp_log.size()), 32'd4);
    exp_rsp(0, 4'd5, 3'b000, 3'b000, 32'd0);
    exp_rsp(3, 4'd8, 3'b000, 3'b000, 32'd0);

    clear_logs();
    push(4'd3, 32'd1);
    push(4'd4, 32'd2);
    push(4'd3, 32'd3);
    push(4'd4, 32'd4);
    drain();
    chk("wrap_rsps", 32'(rsp_log.size()), 32'd4);
    exp_rsp(0, 4'd3, 3'b000, 3'b000, 32'd0);
    exp_rsp(1, 4'd4, 3'b000, 3'b000, 32'd0);
    exp_rsp(2, 4'd3, 3'b000, 3'b000, 32'd0);
    exp_rsp(3, 4'd4, 3'b000, 3'b000, 32'd0);

    clear_logs();
    push(4'd12, 32'd0);
    push(4'd1, 32'h0000_DEAD);
    push(4'd1, KEY);
    drain();
    exp_rsp(0, 4'd12, 3'b110, 3'b000, 32'd0);
    exp_rsp(1, 4'd1,  3'b001, 3'b000, 32'd0);
    exp_rsp(2, 4'd1,  3'b000, 3'b000, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
